arp_tx_arbiter: RTL

- Shares the single 32-bit ARP transmit word path between two requesters: the reply engine (answers received ARP requests) and the request engine (resolves unknown IPs).
- Arbitrates round-robin, latches the winner's target fields, and serialises one 7-word ARP packet with a valid/ready handshake.
- Word layout is identical to the receive parser's 7-word framing, so transmit and receive share one packet format.

---
 rtl/arp_tx_arbiter_if.sv | 27 ++
 rtl/arp_tx_arbiter.sv | 182 ++++++++++++++++++
 2 files changed

// File: rtl/arp_tx_arbiter_if.sv
// Handshake bundle between the two ARP requesters, the transmit arbiter and
// the downstream 32-bit word sink.
interface arp_tx_arbiter_if;
   logic        rep_valid;
   logic [47:0] rep_tha;
   logic [31:0] rep_tpa;
   logic        rep_ack;
   logic        req_valid;
   logic [31:0] req_tpa;
   logic        req_ack;
   logic [31:0] tx_data;
   logic        tx_valid;
   logic        tx_ready;
   logic        tx_last;
   logic        busy;
   logic        grant_id;

   modport slave (
      input  rep_valid, rep_tha, rep_tpa, req_valid, req_tpa, tx_ready,
      output rep_ack, req_ack, tx_data, tx_valid, tx_last, busy, grant_id
   );

   modport master (
      output rep_valid, rep_tha, rep_tpa, req_valid, req_tpa, tx_ready,
      input  rep_ack, req_ack, tx_data, tx_valid, tx_last, busy, grant_id
   );
endinterface

// File: rtl/arp_tx_arbiter.sv
// Round-robin arbiter between the ARP reply and request engines; serialises
// one 7-word ARP packet per grant onto a valid/ready word stream.
module arp_tx_arbiter #(
   parameter logic [47:0] LOCAL_MAC = 48'h02_00_00_00_00_01,
   parameter logic [31:0] LOCAL_IP  = 32'hC0A8_0001,
   parameter logic [15:0] HTYPE     = 16'h0001,
   parameter logic [15:0] PTYPE     = 16'h0800
) (
   input  logic              clk,
   input  logic              rst,
   arp_tx_arbiter_if.slave   io_bus
);

   typedef enum logic [0:0] {
      IDLE = 1'b0,
      SEND = 1'b1
   } state_t;

   state_t      r_state;
   logic [2:0]  r_wordCnt;
   logic [31:0] r_txData;
   logic        r_txValid;
   logic        r_txLast;
   logic        r_repAck;
   logic        r_reqAck;
   logic        r_grantId;
   logic        r_favourReq;
   logic [15:0] r_oper;
   logic [47:0] r_tha;
   logic [31:0] r_tpa;

   state_t      w_state;
   logic [2:0]  w_wordCnt;
   logic [31:0] w_txData;
   logic        w_txValid;
   logic        w_txLast;
   logic        w_repAck;
   logic        w_reqAck;
   logic        w_grantId;
   logic        w_favourReq;
   logic [15:0] w_oper;
   logic [47:0] w_tha;
   logic [31:0] w_tpa;
   logic        w_grantRep;
   logic        w_grantReq;

   // Same 7-word framing as the receive parser.
   function automatic logic [31:0] packetWord(input logic [2:0]  idx,
                                              input logic [15:0] oper,
                                              input logic [47:0] tha,
                                              input logic [31:0] tpa);
      logic [31:0] word;
      case (idx)
         3'd0:    word = {HTYPE, PTYPE};
         3'd1:    word = {8'd6, 8'd4, oper};
         3'd2:    word = LOCAL_MAC[47:16];
         3'd3:    word = {LOCAL_MAC[15:0], LOCAL_IP[31:16]};
         3'd4:    word = {LOCAL_IP[15:0], tha[47:32]};
         3'd5:    word = tha[31:0];
         3'd6:    word = tpa;
         default: word = 32'h0;
      endcase
      return word;
   endfunction

   // A lone requester always wins; a tie goes to the side the pointer favours.
   assign w_grantRep = io_bus.rep_valid && (!io_bus.req_valid || !r_favourReq);
   assign w_grantReq = io_bus.req_valid && (!io_bus.rep_valid ||  r_favourReq);

   always_comb begin
      w_state     = r_state;
      w_wordCnt   = r_wordCnt;
      w_txData    = r_txData;
      w_txValid   = r_txValid;
      w_txLast    = r_txLast;
      w_repAck    = 1'b0;
      w_reqAck    = 1'b0;
      w_grantId   = r_grantId;
      w_favourReq = r_favourReq;
      w_oper      = r_oper;
      w_tha       = r_tha;
      w_tpa       = r_tpa;

      case (r_state)
         IDLE: begin
            w_wordCnt = 3'd0;
            w_txValid = 1'b0;
            w_txLast  = 1'b0;
            if (w_grantRep) begin
               w_oper      = 16'h0002;
               w_tha       = io_bus.rep_tha;
               w_tpa       = io_bus.rep_tpa;
               w_repAck    = 1'b1;
               w_grantId   = 1'b0;
               w_favourReq = 1'b1;
            end else if (w_grantReq) begin
               w_oper      = 16'h0001;
               w_tha       = 48'h0;
               w_tpa       = io_bus.req_tpa;
               w_reqAck    = 1'b1;
               w_grantId   = 1'b1;
               w_favourReq = 1'b0;
            end
            if (w_grantRep || w_grantReq) begin
               w_txData  = packetWord(3'd0, w_oper, w_tha, w_tpa);
               w_txValid = 1'b1;
               w_state   = SEND;
            end
         end

         SEND: begin
            // An out-of-range count can only come from corruption; drop the packet.
            if (r_wordCnt > 3'd6) begin
               w_state   = IDLE;
               w_wordCnt = 3'd0;
               w_txData  = 32'h0;
               w_txValid = 1'b0;
               w_txLast  = 1'b0;
            end else if (io_bus.tx_ready) begin
               if (r_wordCnt == 3'd6) begin
                  w_state   = IDLE;
                  w_wordCnt = 3'd0;
                  w_txData  = 32'h0;
                  w_txValid = 1'b0;
                  w_txLast  = 1'b0;
               end else begin
                  w_wordCnt = r_wordCnt + 3'd1;
                  w_txData  = packetWord(r_wordCnt + 3'd1, r_oper, r_tha, r_tpa);
                  w_txLast  = (r_wordCnt == 3'd5);
               end
            end
         end

         default: begin
            w_state   = IDLE;
            w_wordCnt = 3'd0;
            w_txData  = 32'h0;
            w_txValid = 1'b0;
            w_txLast  = 1'b0;
         end
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state     <= IDLE;
         r_wordCnt   <= 3'd0;
         r_txData    <= 32'h0;
         r_txValid   <= 1'b0;
         r_txLast    <= 1'b0;
         r_repAck    <= 1'b0;
         r_reqAck    <= 1'b0;
         r_grantId   <= 1'b0;
         r_favourReq <= 1'b0;
         r_oper      <= 16'h0;
         r_tha       <= 48'h0;
         r_tpa       <= 32'h0;
      end else begin
         r_state     <= w_state;
         r_wordCnt   <= w_wordCnt;
         r_txData    <= w_txData;
         r_txValid   <= w_txValid;
         r_txLast    <= w_txLast;
         r_repAck    <= w_repAck;
         r_reqAck    <= w_reqAck;
         r_grantId   <= w_grantId;
         r_favourReq <= w_favourReq;
         r_oper      <= w_oper;
         r_tha       <= w_tha;
         r_tpa       <= w_tpa;
      end
   end

   assign io_bus.rep_ack  = r_repAck;
   assign io_bus.req_ack  = r_reqAck;
   assign io_bus.tx_data  = r_txData;
   assign io_bus.tx_valid = r_txValid;
   assign io_bus.tx_last  = r_txLast;
   assign io_bus.busy     = (r_state == SEND);
   assign io_bus.grant_id = r_grantId;

endmodule
